// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the pipeline normally owns the single memory port, while a
// debug/loader port is granted when the pipeline is idle or after a bounded wait.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_MR,
    output logic              mem_MW,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                d_ok;
    logic                grant_d;
    logic                grant_p;

    // Debug handshake: d_req is a level request held by the requester until d_ack;
    // d_ack pulses for one cycle, the cycle after the grant, with d_rdata valid alongside.
    always_comb begin
        state_d     = ST_IDLE;
        wait_cnt_d  = wait_cnt_q;
        d_ack_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        stall_cnt_d = stall_cnt_q;
        d_ok        = 1'b0;
        grant_d     = 1'b0;
        grant_p     = 1'b0;
        mem_MR      = 1'b0;
        mem_MW      = 1'b0;
        mem_addr    = '0;
        mem_wd      = '0;
        p_stall     = 1'b0;

        if (!rst) begin
            d_ok    = d_req && (state_q == ST_IDLE);
            grant_d = d_ok && (!p_req || (wait_cnt_q == WAIT_MAX));
            grant_p = !grant_d && p_req;
        end

        if (grant_d) begin
            mem_MR   = !d_we;
            mem_MW   = d_we;
            mem_addr = d_addr;
            mem_wd   = d_wdata;
            p_stall  = p_req;
            state_d  = ST_ACK;
            d_ack_d  = 1'b1;
            if (!d_we) begin
                d_rdata_d = mem_rd;
            end
        end else if (grant_p) begin
            mem_MR   = !p_we;
            mem_MW   = p_we;
            mem_addr = p_addr;
            mem_wd   = p_wdata;
        end

        // In ACK d_ok is low, so the count can only hold or clear there.
        if (grant_d || !d_req) begin
            wait_cnt_d = '0;
        end else if (d_ok && grant_p && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        if (p_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A reset arriving in the ACK cycle drops the pending acknowledge.
    assign d_ack     = d_ack_q & ~rst;
    assign d_rdata   = d_rdata_q;
    assign stall_cnt = stall_cnt_q;
    assign p_rdata   = mem_rd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand sequences for reset/MAX_WAIT=0,
// and random traffic checked against a behavioural arbitration model.
module tb_dmem_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_req, p_we, d_req, d_we;
    logic [31:0] p_addr, p_wdata, d_addr, d_wdata;

    logic [31:0] p_rdata, d_rdata, mem_addr, mem_wd, mem_rd;
    logic        p_stall, d_ack, mem_MR, mem_MW;
    logic [15:0] stall_cnt;

    logic [31:0] p_rdata_0, d_rdata_0, mem_addr_0, mem_wd_0, mem_rd_0;
    logic        p_stall_0, d_ack_0, mem_MR_0, mem_MW_0;
    logic [3:0]  stall_cnt_0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [256] = '{default: 8'h00};

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_MR(mem_MR), .mem_MW(mem_MW), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .stall_cnt(stall_cnt)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata_0), .p_stall(p_stall_0),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_0), .d_ack(d_ack_0),
        .mem_MR(mem_MR_0), .mem_MW(mem_MW_0), .mem_addr(mem_addr_0), .mem_wd(mem_wd_0),
        .mem_rd(mem_rd_0), .stall_cnt(stall_cnt_0)
    );

    // Byte-addressed little-endian memory, 256 bytes, wrapping.
    assign mem_rd = {mem[mem_addr[7:0] + 8'd3], mem[mem_addr[7:0] + 8'd2],
                     mem[mem_addr[7:0] + 8'd1], mem[mem_addr[7:0]]};
    assign mem_rd_0 = mem_addr_0 ^ 32'h5A5A_0000;

    always @(posedge clk) begin
        if (mem_MW) begin
            mem[mem_addr[7:0]]         <= mem_wd[7:0];
            mem[mem_addr[7:0] + 8'd1]  <= mem_wd[15:8];
            mem[mem_addr[7:0] + 8'd2]  <= mem_wd[23:16];
            mem[mem_addr[7:0] + 8'd3]  <= mem_wd[31:24];
        end
    end

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit pr, input bit pw, input logic [31:0] pa, input logic [31:0] pd,
                         input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    // Reference model: debug has a pending acknowledge for one cycle after any debug
    // access; otherwise debug wins when the pipeline is idle or it has been refused MW times.
    bit          m_known       = 1'b0;
    bit          m_ack_pending = 1'b0;
    bit          m_ack_out     = 1'b0;
    int          m_waited      = 0;
    int          m_stalls      = 0;
    logic [31:0] m_rdata       = '0;

    // Called at the negedge: checks this cycle against the model, advances it, steps a cycle.
    task automatic tick();
        bit dbg_win, pipe_win, debug_eligible;
        bit e_mr, e_mw, e_st;
        logic [31:0] e_a, e_wd;
        debug_eligible = !rst && d_req && !m_ack_pending;
        dbg_win  = debug_eligible && (!p_req || m_waited >= MW);
        pipe_win = !rst && p_req && !dbg_win;
        e_mr = 0; e_mw = 0; e_st = 0; e_a = '0; e_wd = '0;
        if (dbg_win) begin
            e_mr = !d_we; e_mw = d_we; e_a = d_addr; e_wd = d_wdata; e_st = p_req;
        end else if (pipe_win) begin
            e_mr = !p_we; e_mw = p_we; e_a = p_addr; e_wd = p_wdata;
        end
        chk("model_mem_MR", mem_MR, e_mr);
        chk("model_mem_MW", mem_MW, e_mw);
        chk("model_mem_addr", mem_addr, e_a);
        chk("model_mem_wd", mem_wd, e_wd);
        chk("model_p_stall", p_stall, e_st);
        chk("model_p_rdata", p_rdata, mem_read(e_a));
        if (m_known) begin
            chk("model_d_ack", d_ack, m_ack_out && !rst);
            chk("model_d_rdata", d_rdata, m_rdata);
            chk("model_stall_cnt", stall_cnt, 64'(m_stalls));
        end
        if (rst) begin
            m_known = 1'b1; m_ack_pending = 1'b0; m_ack_out = 1'b0;
            m_waited = 0; m_stalls = 0; m_rdata = '0;
        end else begin
            if (dbg_win && !d_we) m_rdata = mem_read(d_addr);
            m_ack_out     = dbg_win;
            m_ack_pending = dbg_win;
            if (dbg_win || !d_req) m_waited = 0;
            else if (debug_eligible && pipe_win && m_waited < MW) m_waited++;
            if (e_st && m_stalls < 65535) m_stalls++;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit pr; bit pw; logic [31:0] pa; logic [31:0] pd;
        bit dr; bit dw; logic [31:0] da; logic [31:0] dd;
        bit emr; bit emw; logic [31:0] ea; logic [31:0] ewd;
        bit est; bit edack; bit chk_pr; logic [31:0] eprd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Idle debug write, read-back, no double issue, simultaneous writers,
        // withdrawal clearing the wait count, then starvation on addr 30.
        vecs.push_back('{0,0,32'd0,32'd0,  1,1,32'd16,32'hDEADBEEF, 0,1,32'd16,32'hDEADBEEF, 0,0,0,32'd0});
        vecs.push_back('{0,0,32'd0,32'd0,  1,1,32'd16,32'hDEADBEEF, 0,0,32'd0,32'd0,         0,1,0,32'd0});
        vecs.push_back('{1,0,32'd16,32'd0, 0,0,32'd0,32'd0,         1,0,32'd16,32'd0,        0,0,1,32'hDEADBEEF});
        for (int k = 0; k < 3; k++) begin
            vecs.push_back('{0,0,32'd0,32'd0, 1,0,32'd16,32'd0, 1,0,32'd16,32'd0, 0,0,0,32'd0});
            vecs.push_back('{0,0,32'd0,32'd0, 1,0,32'd16,32'd0, 0,0,32'd0,32'd0,  0,1,0,32'd0});
        end
        vecs.push_back('{1,1,32'd40,32'hCAFEF00D, 0,0,32'd0,32'd0, 0,1,32'd40,32'hCAFEF00D, 0,0,0,32'd0});
        vecs.push_back('{1,0,32'd40,32'd0,        0,0,32'd0,32'd0, 1,0,32'd40,32'd0,        0,0,1,32'hCAFEF00D});
        vecs.push_back('{1,1,32'd48,32'h11111111, 1,1,32'd48,32'h22222222, 0,1,32'd48,32'h11111111, 0,0,0,32'd0});
        vecs.push_back('{0,0,32'd0,32'd0,         1,1,32'd48,32'h22222222, 0,1,32'd48,32'h22222222, 0,0,0,32'd0});
        vecs.push_back('{1,0,32'd48,32'd0,        0,0,32'd0,32'd0,         1,0,32'd48,32'd0,        0,1,1,32'h22222222});
        vecs.push_back('{1,1,32'd30,32'h44332211, 0,0,32'd0,32'd0,         0,1,32'd30,32'h44332211, 0,0,0,32'd0});
        vecs.push_back('{1,0,32'd64,32'd0, 1,0,32'd30,32'd0, 1,0,32'd64,32'd0, 0,0,0,32'd0});
        vecs.push_back('{1,0,32'd64,32'd0, 1,0,32'd30,32'd0, 1,0,32'd64,32'd0, 0,0,0,32'd0});
        vecs.push_back('{1,0,32'd64,32'd0, 0,0,32'd0,32'd0,  1,0,32'd64,32'd0, 0,0,0,32'd0});
        for (int k = 0; k < 4; k++)
            vecs.push_back('{1,0,32'd64,32'd0, 1,0,32'd30,32'd0, 1,0,32'd64,32'd0, 0,0,0,32'd0});
        vecs.push_back('{1,0,32'd64,32'd0, 1,0,32'd30,32'd0, 1,0,32'd30,32'd0, 1,0,0,32'd0});
        vecs.push_back('{1,0,32'd64,32'd0, 1,0,32'd30,32'd0, 1,0,32'd64,32'd0, 0,1,0,32'd0});

        // Reset and reset values.
        rst = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk); tick();
        @(negedge clk);
        chk("rst_mem_MR", mem_MR, 0);
        chk("rst_mem_MW", mem_MW, 0);
        chk("rst_p_stall", p_stall, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_d_ack", d_ack, 0);
        chk("reset_d_rdata", d_rdata, 0);
        chk("reset_stall_cnt", stall_cnt, 0);
        chk("reset_stall_cnt_0", stall_cnt_0, 0);
        chk("reset_mem_addr", mem_addr, 0);
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].pr, vecs[i].pw, vecs[i].pa, vecs[i].pd,
                  vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
            @(negedge clk);
            chk($sformatf("v%0d_mem_MR", i), mem_MR, vecs[i].emr);
            chk($sformatf("v%0d_mem_MW", i), mem_MW, vecs[i].emw);
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].ea);
            chk($sformatf("v%0d_mem_wd", i), mem_wd, vecs[i].ewd);
            chk($sformatf("v%0d_p_stall", i), p_stall, vecs[i].est);
            chk($sformatf("v%0d_d_ack", i), d_ack, vecs[i].edack);
            if (vecs[i].chk_pr) chk($sformatf("v%0d_p_rdata", i), p_rdata, vecs[i].eprd);
            tick();
        end

        // After starvation: debug read data from addr 30 and exactly one stall so far.
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("starve_d_rdata", d_rdata, 32'h44332211);
        chk("starve_stall_cnt", stall_cnt, 1);
        tick();

        // Reset in the ACK cycle: acknowledge is dropped, registers clear.
        drive(0, 0, '0, '0, 1, 1, 32'd80, 32'h0BADF00D);
        @(negedge clk);
        chk("rstack_grant_MW", mem_MW, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstack_d_ack", d_ack, 0);
        chk("rstack_mem_MW", mem_MW, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("rstack_after_d_ack", d_ack, 0);
        chk("rstack_after_d_rdata", d_rdata, 0);
        chk("rstack_after_stall_cnt", stall_cnt, 0);
        tick();

        // MAX_WAIT=0 instance: debug wins every IDLE cycle; CNT_W=4 counter saturates at 15.
        drive(1, 0, 32'd100, '0, 1, 1, 32'd120, 32'h00000077);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk($sformatf("mw0_p_stall_%0d", k), p_stall_0, (k % 2 == 0));
            chk($sformatf("mw0_mem_addr_%0d", k), mem_addr_0, (k % 2 == 0) ? 32'd120 : 32'd100);
            chk($sformatf("mw0_stall_cnt_%0d", k), stall_cnt_0, ((k + 1) / 2 > 15) ? 15 : (k + 1) / 2);
            tick();
        end
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("mw0_stall_cnt_sat", stall_cnt_0, 15);
        tick();

        // Random traffic against the model, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 1), $urandom_range(0, 1), 32'($urandom_range(0, 255)), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1), 32'($urandom_range(0, 255)), $urandom);
            @(negedge clk);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
